// File: rtl/fpu_pkg.sv
// Shared FPU definitions: op encodings, default unit latencies and an op-legality helper.
package fpu_pkg;

  typedef enum logic [3:0] {
    FPU_NOP = 4'h0,
    FPU_ADD = 4'h8,
    FPU_SUB = 4'h9,
    FPU_MUL = 4'hA,
    FPU_DIV = 4'hB
  } fpu_op_e;

  localparam int FPU_ADD_LAT_DEF  = 4;
  localparam int FPU_MULT_LAT_DEF = 4;
  localparam int FPU_DIV_LAT_DEF  = 28;
  localparam int FPU_DIV_II_DEF   = 26;

  // The FPU occupies codes 8..B, i.e. exactly the 4'b10xx block.
  function automatic logic is_fpu_op(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/fpu_wb_reserve.sv
// Writeback reservation shift register: bit k set means an FPU result lands on the
// shared normalize/writeback slot k cycles from now.
module fpu_wb_reserve #(
  parameter int DEPTH = 28,
  parameter int LAT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             rsv_en,
  input  logic [LAT_W-1:0] rsv_lat,
  output logic             slot_free,
  output logic             due_now,
  output logic             due_next,
  output logic             empty
);

  logic [DEPTH:0] res_q;
  logic [DEPTH:0] res_nxt;

  // A new op lands L cycles after accept; after this edge's shift that is bit L-1.
  always_comb begin
    res_nxt = res_q >> 1;
    if (rsv_en) res_nxt[rsv_lat - LAT_W'(1)] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) res_q <= '0;
    else          res_q <= res_nxt;
  end

  assign slot_free = !res_q[rsv_lat];
  assign due_now   = res_q[0];
  assign due_next  = res_q[1];
  assign empty     = (res_q == '0);

endmodule

// File: rtl/fpu_issue_sched.sv
// Issue scheduler in front of the FPU: holds each op until registers, divider and the
// writeback slot are all free, then drives the FPU one cycle after accept.
module fpu_issue_sched
  import fpu_pkg::*;
#(
  parameter int ADD_LAT  = FPU_ADD_LAT_DEF,
  parameter int MULT_LAT = FPU_MULT_LAT_DEF,
  parameter int DIV_LAT  = FPU_DIV_LAT_DEF,
  parameter int DIV_II   = FPU_DIV_II_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_src_a,
  input  logic [4:0]  req_src_b,
  input  logic        req_use_a,
  input  logic        req_use_b,
  input  logic [4:0]  req_dest,
  output logic [3:0]  fpu_op,
  output logic [31:0] fpu_in_a,
  output logic [31:0] fpu_in_b,
  output logic [4:0]  fpu_in_dest,
  input  logic        fpu_valid,
  input  logic [4:0]  fpu_dest,
  output logic [31:0] busy_mask,
  output logic        fpu_wb_next,
  output logic        idle,
  output logic        illegal_op,
  output logic        sched_err
);

  localparam int MAX_AM  = (ADD_LAT > MULT_LAT) ? ADD_LAT : MULT_LAT;
  localparam int MAX_LAT = (DIV_LAT > MAX_AM) ? DIV_LAT : MAX_AM;
  localparam int LAT_W   = $clog2(MAX_LAT + 1);
  localparam int CNT_W   = $clog2(DIV_II + 1);

  logic             op_legal;
  logic             is_div;
  logic [LAT_W-1:0] op_lat;
  logic             hazard;
  logic             div_block;
  logic             slot_free;
  logic             accept;
  logic             acc_legal;
  logic             due_now;
  logic             due_next;
  logic             res_empty;

  logic [31:0]      busy_q;
  logic [31:0]      busy_nxt;
  logic [CNT_W-1:0] div_cnt_q;
  logic [3:0]       op_p1;
  logic [31:0]      a_p1;
  logic [31:0]      b_p1;
  logic [4:0]       dest_p1;
  logic             illegal_p1;
  logic             sched_err_q;

  // Stage 0: hazard, divider and writeback-slot checks against registered state
  assign op_legal = is_fpu_op(req_op);
  assign is_div   = (req_op == FPU_DIV);

  always_comb begin
    case (req_op)
      FPU_ADD, FPU_SUB: op_lat = LAT_W'(ADD_LAT);
      FPU_MUL:          op_lat = LAT_W'(MULT_LAT);
      FPU_DIV:          op_lat = LAT_W'(DIV_LAT);
      default:          op_lat = LAT_W'(ADD_LAT);
    endcase
  end

  assign hazard    = (busy_q[req_src_a] & req_use_a) |
                     (busy_q[req_src_b] & req_use_b) |
                      busy_q[req_dest];
  assign div_block = is_div && (div_cnt_q != '0);

  // Illegal ops are swallowed immediately so a bad opcode can never wedge decode.
  assign req_ready = !op_legal || !(hazard || div_block || !slot_free);
  assign accept    = req_valid && req_ready;
  assign acc_legal = accept && op_legal;

  fpu_wb_reserve #(
    .DEPTH (MAX_LAT),
    .LAT_W (LAT_W)
  ) u_wb_reserve (
    .clock     (clock),
    .reset_n   (reset_n),
    .rsv_en    (acc_legal),
    .rsv_lat   (op_lat),
    .slot_free (slot_free),
    .due_now   (due_now),
    .due_next  (due_next),
    .empty     (res_empty)
  );

  always_comb begin
    busy_nxt = busy_q;
    if (fpu_valid) busy_nxt[fpu_dest] = 1'b0;
    if (acc_legal && (req_dest != 5'd0)) busy_nxt[req_dest] = 1'b1;
  end

  // Stage 1: registered scheduler state and FPU drive
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q      <= '0;
      div_cnt_q   <= '0;
      op_p1       <= 4'h0;
      illegal_p1  <= 1'b0;
      sched_err_q <= 1'b0;
    end else begin
      busy_q      <= busy_nxt;
      op_p1       <= acc_legal ? req_op : 4'h0;
      illegal_p1  <= accept && !op_legal;
      sched_err_q <= sched_err_q | (fpu_valid != due_now);
      if (acc_legal && is_div)    div_cnt_q <= CNT_W'(DIV_II - 1);
      else if (div_cnt_q != '0)   div_cnt_q <= div_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_p1    <= '0;
      b_p1    <= '0;
      dest_p1 <= '0;
    end else if (acc_legal) begin
      a_p1    <= req_a;
      b_p1    <= req_b;
      dest_p1 <= req_dest;
    end
  end

  assign fpu_op      = op_p1;
  assign fpu_in_a    = a_p1;
  assign fpu_in_b    = b_p1;
  assign fpu_in_dest = dest_p1;
  assign busy_mask   = busy_q;
  assign fpu_wb_next = due_next;
  assign idle        = (busy_q == '0) && res_empty && (div_cnt_q == '0);
  assign illegal_op  = illegal_p1;
  assign sched_err   = sched_err_q;

endmodule
